// File: rtl/pic_bus_interface.sv
// Clocked 8259A data bus buffer plus the small show-ahead FIFO that queues completed CPU writes.
// Strobes, address and data are re-timed into clk; the control logic drains writes through valid/ready.

// Generic show-ahead FIFO: the head word is presented combinationally whenever the queue is non-empty.
// Latency: a push into an empty queue is visible the cycle after the push edge.
// Backpressure: a push while full is dropped (push_drop) unless a pop happens in the same cycle.
module pic_bus_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   push_drop,
  output logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  input  logic                   pop_rdy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_LVL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   LVL_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full      = (level == FULL_LVL);
  assign pop_vld   = (level != '0);
  assign pop_dat   = mem[rd_ptr];
  assign do_pop    = pop_vld && pop_rdy;
  // At full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign do_push   = push_vld && (!full || do_pop);
  assign push_drop = push_vld && full && !do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        level <= level + LVL_ONE;
      end else if (!do_push && do_pop) begin
        level <= level - LVL_ONE;
      end
    end
  end
endmodule

// CPU bus front end: synchronises cs_n/rd_n/wr_n, queues writes, turns reads into rd_req + held read-back.
// Latency: S+1 edges from the first sampling edge of a strobe edge to push / rd_req; oe one edge later.
// Backpressure: wr_ready throttles the write queue; overflow and strobe conflicts raise sticky overrun.
module pic_bus_interface #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cs_n,
  input  logic                         rd_n,
  input  logic                         wr_n,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        data_bus_in,
  output logic [DATA_WIDTH-1:0]        data_bus_out,
  output logic                         data_bus_oe,
  output logic                         wr_valid,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic                         wr_ready,
  output logic                         rd_req,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int S  = SYNC_STAGES;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [S-1:0]          cs_sync;
  logic [S-1:0]          rd_sync;
  logic [S-1:0]          wr_sync;
  logic [ADDR_WIDTH-1:0] addr_pipe [S];
  logic [DATA_WIDTH-1:0] data_pipe [S];
  logic                  rd_prev;
  logic                  wr_prev;

  logic                  cs_s;
  logic                  rd_s;
  logic                  wr_s;
  logic                  sel;
  logic                  wr_rise;
  logic                  rd_fall;
  logic                  wr_event;
  logic                  rd_event;
  logic                  conflict;
  logic [ADDR_WIDTH-1:0] addr_al;
  logic [DATA_WIDTH-1:0] data_al;
  logic                  push_drop;
  logic [EW-1:0]         head;

  // Strobe synchronisers reset inactive, so a strobe held low through reset looks like a fresh falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync <= '1;
      rd_sync <= '1;
      wr_sync <= '1;
      for (int i = 0; i < S; i++) begin
        addr_pipe[i] <= '0;
        data_pipe[i] <= '0;
      end
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      cs_sync      <= {cs_sync[S-2:0], cs_n};
      rd_sync      <= {rd_sync[S-2:0], rd_n};
      wr_sync      <= {wr_sync[S-2:0], wr_n};
      addr_pipe[0] <= addr;
      data_pipe[0] <= data_bus_in;
      for (int i = 1; i < S; i++) begin
        addr_pipe[i] <= addr_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
      rd_prev <= rd_s;
      wr_prev <= wr_s;
    end
  end

  assign cs_s    = cs_sync[S-1];
  assign rd_s    = rd_sync[S-1];
  assign wr_s    = wr_sync[S-1];
  assign addr_al = addr_pipe[S-1];
  assign data_al = data_pipe[S-1];

  assign sel      = !cs_s;
  assign wr_rise  = wr_s && !wr_prev;
  assign rd_fall  = !rd_s && rd_prev;
  assign wr_event = sel && wr_rise && rd_s;
  assign rd_event = sel && rd_fall && wr_s;
  assign conflict = sel && ((wr_rise && !rd_s) || (rd_fall && !wr_s));

  pic_bus_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_vld  (wr_event),
    .push_dat  ({addr_al, data_al}),
    .push_drop (push_drop),
    .pop_vld   (wr_valid),
    .pop_dat   (head),
    .pop_rdy   (wr_ready),
    .level     (fifo_level)
  );

  assign {wr_addr, wr_data} = head;

  // Read-back register keeps its last value after oe drops so the pins never see rd_data churn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      data_bus_out <= '0;
      data_bus_oe  <= 1'b0;
    end else begin
      rd_req <= rd_event;
      if (rd_event) begin
        rd_addr <= addr_al;
      end
      if (rd_req) begin
        data_bus_out <= rd_data;
      end
      data_bus_oe <= rd_req || (data_bus_oe && !rd_s && !cs_s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (conflict || push_drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pic_bus_interface.sv
// Bench for pic_bus_interface: CPU bus transactions are scheduled into expectation queues by edge number;
// a negedge monitor keeps a transaction-level model of the write queue, reads and the overrun flag.
module tb_pic_bus_interface;
  localparam int DW    = 8;
  localparam int AW    = 1;
  localparam int S     = 2;
  localparam int D     = 4;
  localparam int LW    = $clog2(D) + 1;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cs_n = 1'b0;
  logic          rd_n = 1'b1;
  logic          wr_n = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_bus_in = '0;
  logic [DW-1:0] data_bus_out;
  logic          data_bus_oe;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_ready = 1'b0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          overrun;
  logic          overrun_clr = 1'b0;
  logic [LW-1:0] fifo_level;

  pic_bus_interface #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (S),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .addr         (addr),
    .data_bus_in  (data_bus_in),
    .data_bus_out (data_bus_out),
    .data_bus_oe  (data_bus_oe),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .wr_ready     (wr_ready),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct { int at; logic [AW-1:0] a; logic [DW-1:0] d; } wr_ev_t;
  typedef struct { int at; logic [AW-1:0] a; } rd_ev_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;

  wr_ev_t        pend_wr[$];
  rd_ev_t        pend_rd[$];
  int            pend_cf[$];
  ent_t          mq[$];
  bit            m_ovr = 1'b0;
  logic [DW-1:0] m_out = '0;
  int            oe_lo = NEVER;
  int            oe_hi = NEVER;
  bit            in_reset = 1'b0;
  bit            rand_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals();
    chk("rst data_bus_out", 32'(data_bus_out), 0);
    chk("rst data_bus_oe",  32'(data_bus_oe), 0);
    chk("rst wr_valid",     32'(wr_valid), 0);
    chk("rst wr_data",      32'(wr_data), 0);
    chk("rst wr_addr",      32'(wr_addr), 0);
    chk("rst rd_req",       32'(rd_req), 0);
    chk("rst rd_addr",      32'(rd_addr), 0);
    chk("rst overrun",      32'(overrun), 0);
    chk("rst fifo_level",   32'(fifo_level), 0);
  endtask

  // A well-formed CPU write: push lands S edges after the first edge that samples the wr_n rise.
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int low_cyc,
                           input bit pop_at_push);
    addr = a;
    data_bus_in = d;
    tick(S + 1);
    wr_n = 1'b0;
    tick(low_cyc);
    wr_n = 1'b1;
    pend_wr.push_back('{at: edge_no + 1 + S, a: a, d: d});
    if (pop_at_push) begin
      tick(S);
      wr_ready = 1'b1;
      tick(1);
      wr_ready = 1'b0;
      tick(1);
    end else begin
      tick(S + 1);
    end
  endtask

  // A well-formed CPU read; rd_data is changed to d2 after the capture edge.
  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] d2,
                          input int low_cyc);
    int k;
    addr = a;
    rd_data = d;
    tick(S + 1);
    rd_n = 1'b0;
    k = edge_no + 1;
    pend_rd.push_back('{at: k + S + 1, a: a});
    oe_lo = k + S + 2;
    oe_hi = NEVER;
    tick(S + 3);
    rd_data = d2;
    tick(low_cyc - (S + 3));
    rd_n = 1'b1;
    oe_hi = edge_no + 1 + S;
    tick(S + 3);
  endtask

  task automatic clr_ovr();
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    tick(1);
  endtask

  int  e;
  bit  pop;
  bit  drop;
  bit  setf;
  bit  exp_req;

  // Monitor: compare outputs against the model state, then advance the model across edge e.
  always @(negedge clk) begin
    if (in_reset) begin
      mq.delete();
      pend_wr.delete();
      pend_rd.delete();
      pend_cf.delete();
      m_ovr = 1'b0;
      m_out = '0;
      oe_lo = NEVER;
      oe_hi = NEVER;
    end else begin
      e = edge_no + 1;
      chk("wr_valid", 32'(wr_valid), 32'(mq.size() != 0));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      if (mq.size() != 0) begin
        chk("wr_data", 32'(wr_data), 32'(mq[0].d));
        chk("wr_addr", 32'(wr_addr), 32'(mq[0].a));
      end
      exp_req = (pend_rd.size() != 0) && (pend_rd[0].at == e);
      chk("rd_req", 32'(rd_req), 32'(exp_req));
      if (exp_req) begin
        chk("rd_addr", 32'(rd_addr), 32'(pend_rd[0].a));
        void'(pend_rd.pop_front());
      end
      chk("data_bus_oe", 32'(data_bus_oe), 32'((e >= oe_lo) && (e <= oe_hi)));
      chk("data_bus_out", 32'(data_bus_out), 32'(m_out));
      chk("overrun", 32'(overrun), 32'(m_ovr));

      pop = (mq.size() != 0) && wr_ready;
      if (pop) void'(mq.pop_front());
      drop = 1'b0;
      if ((pend_wr.size() != 0) && (pend_wr[0].at == e)) begin
        if (mq.size() < D) mq.push_back('{a: pend_wr[0].a, d: pend_wr[0].d});
        else drop = 1'b1;
        void'(pend_wr.pop_front());
      end
      setf = drop;
      if ((pend_cf.size() != 0) && (pend_cf[0] == e)) begin
        setf = 1'b1;
        void'(pend_cf.pop_front());
      end
      if (setf) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      if (exp_req) m_out = rd_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_no);
    $fatal(1);
  end

  initial begin
    int k;
    #1;
    in_reset = 1'b1;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    tick(3);
    reset = 1'b0;
    in_reset = 1'b0;
    tick(S + 2);

    // single write drained immediately
    wr_ready = 1'b1;
    cpu_write(1'b1, 8'hAB, 6, 1'b0);
    tick(2);

    // single read, rd_data changes after capture
    cpu_read(1'b1, 8'hCD, 8'h99, 8);
    cpu_read(1'b0, 8'h42, 8'h17, 6);

    // overflow: five writes into a depth-4 queue with no drain
    wr_ready = 1'b0;
    for (int i = 1; i <= 5; i++) cpu_write(AW'(i % 2), DW'(i * 17), 4, 1'b0);
    tick(2);
    wr_ready = 1'b1;
    tick(D + 2);
    wr_ready = 1'b0;
    clr_ovr();

    // push and pop on the same edge while full
    for (int i = 0; i < D; i++) cpu_write(AW'(i % 2), DW'(8'hA0 + i), 3, 1'b0);
    cpu_write(1'b1, 8'hE5, 3, 1'b1);
    wr_ready = 1'b1;
    tick(D + 2);
    wr_ready = 1'b0;

    // randomised writes against a sparsely asserted wr_ready
    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++)
          cpu_write(AW'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), $urandom_range(S + 1, 6), 1'b0);
        rand_rdy = 1'b0;
      end
      begin
        while (rand_rdy) begin
          wr_ready = ($urandom_range(0, 7) == 0);
          tick(1);
        end
      end
    join
    wr_ready = 1'b1;
    tick(D + 3);
    clr_ovr();

    // strobe conflict; clear held through the first set edge
    overrun_clr = 1'b1;
    addr = 1'b0;
    data_bus_in = 8'h66;
    tick(S + 1);
    rd_n = 1'b0;
    wr_n = 1'b0;
    pend_cf.push_back(edge_no + 1 + S);
    tick(S + 2);
    overrun_clr = 1'b0;
    tick(3);
    wr_n = 1'b1;
    pend_cf.push_back(edge_no + 1 + S);
    tick(6);
    rd_n = 1'b1;
    tick(S + 3);
    clr_ovr();

    // deselected strobes are ignored
    cs_n = 1'b1;
    tick(S + 2);
    data_bus_in = 8'h77;
    wr_n = 1'b0;
    tick(4);
    wr_n = 1'b1;
    tick(4);
    rd_n = 1'b0;
    tick(5);
    rd_n = 1'b1;
    tick(S + 2);
    cs_n = 1'b0;
    tick(S + 2);

    // reset during a read; rd_n still low at release gives a fresh read
    addr = 1'b1;
    rd_data = 8'h5A;
    tick(S + 1);
    rd_n = 1'b0;
    k = edge_no + 1;
    pend_rd.push_back('{at: k + S + 1, a: 1'b1});
    oe_lo = k + S + 2;
    oe_hi = NEVER;
    tick(S + 3);
    reset = 1'b1;
    in_reset = 1'b1;
    #1;
    chk_reset_vals();
    rd_data = 8'h3C;
    tick(2);
    reset = 1'b0;
    k = edge_no + 1;
    pend_rd.push_back('{at: k + S + 1, a: 1'b1});
    oe_lo = k + S + 2;
    oe_hi = NEVER;
    in_reset = 1'b0;
    tick(7);
    rd_n = 1'b1;
    oe_hi = edge_no + 1 + S;
    tick(S + 4);

    chk("pending writes", 32'(pend_wr.size()), 0);
    chk("pending reads", 32'(pend_rd.size()), 0);
    chk("pending conflicts", 32'(pend_cf.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
